prog_loader: RTL

Program loader for the 8-bit accumulator processor. It takes a length-prefixed, checksummed byte stream over a valid/ready handshake and writes it into the 32×8 program/data RAM from address 0. It holds the CPU in reset while loading and releases it once a valid image is in memory. It sits between the host/serial front end and the RAM write port, muxed ahead of the CPU's own write path.

---
 rtl/prog_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Loads a length-prefixed, checksummed program image from a byte stream into
// the 32x8 program/data RAM, starting at address 0. The CPU is held in reset
// while a load is in progress. It is released only after a complete image
// with a correct checksum has been written.
//
// Stream format: N (1..2^ADDR_W), then N data bytes, then C. The image is
// good when (sum of data bytes + C) mod 256 == 0. N is not part of the sum.
//
// Handshake: RxData is transferred on a rising edge where RxValid and RxReady
// are both 1. RxReady depends only on the loader state, never on RxValid.
// A source may hold RxValid high for back-to-back bytes or drop it for any
// number of cycles. A cycle without a transfer changes nothing.
//
// Ports:
//   Clock, Reset   rising-edge clock; asynchronous active-low reset
//   LoadReq        level; start a load (sampled in IDLE, RUN, ERR)
//   RunReq         level; release the CPU without loading (IDLE only)
//   RxData/RxValid stream byte and its valid flag
//   RxReady        loader accepts a byte this cycle (LEN, DATA, SUM)
//   MemAddr/MemData/MemWr  RAM write port; MemWr is combinational in DATA
//   CpuReset_n     CPU reset, active-low; high only in RUN
//   Busy           load in progress (LEN, DATA, SUM)
//   Error          last load failed (ERR)
//   DebugState     current FSM state encoding
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LoadReq,
    input  logic              RunReq,
    input  logic [DATA_W-1:0] RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    output logic              MemWr,
    output logic              CpuReset_n,
    output logic              Busy,
    output logic              Error,
    output logic [2:0]        DebugState
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_SUM  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam int DEPTH = 1 << ADDR_W;

    logic [2:0]        state;
    // One spare bit so the counter can step past the last address of a full
    // 2^ADDR_W image without wrapping back to 0.
    logic [ADDR_W:0]   addr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] acc;

    logic              accept;
    logic [DATA_W:0]   len_ext;
    logic              len_ok;
    logic [DATA_W-1:0] sum_final;

    assign accept    = RxValid && RxReady;
    assign len_ext   = {1'b0, RxData};
    assign len_ok    = (RxData != '0) && (len_ext <= (DATA_W+1)'(DEPTH));
    assign sum_final = acc + RxData;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            acc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (LoadReq)     state <= S_LEN;
                    else if (RunReq) state <= S_RUN;
                end
                S_LEN: begin
                    if (accept) begin
                        if (len_ok) begin
                            remaining <= RxData[ADDR_W:0];
                            addr      <= '0;
                            acc       <= '0;
                            state     <= S_DATA;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        addr      <= addr + (ADDR_W+1)'(1);
                        acc       <= acc + RxData;
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1)) state <= S_SUM;
                    end
                end
                S_SUM: begin
                    if (accept) state <= (sum_final == '0) ? S_RUN : S_ERR;
                end
                S_RUN, S_ERR: begin
                    if (LoadReq) state <= S_LEN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign RxReady    = (state == S_LEN) || (state == S_DATA) || (state == S_SUM);
    assign Busy       = RxReady;
    assign MemWr      = (state == S_DATA) && RxValid;
    assign MemAddr    = addr[ADDR_W-1:0];
    assign MemData    = RxData;
    assign CpuReset_n = (state == S_RUN);
    assign Error      = (state == S_ERR);
    assign DebugState = state;

endmodule
